// File: rtl/count_seq_pkg.sv
// count_seq_pkg: shared state encoding and width default for the count sequencer.
package count_seq_pkg;
    localparam int WIDTH_DEF = 4;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_e;
endpackage

// File: rtl/count_sequencer_edge_detect.sv
// edge_detect: one-cycle rising-edge pulse; history resets high so a level held
// through reset release never produces an event.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic in_i,
    output logic evt_o
);
    logic prev_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) prev_q <= 1'b1;
        else      prev_q <= in_i;
    end
    assign evt_o = in_i & ~prev_q;
endmodule

// File: rtl/count_sequencer.sv
// count_sequencer: button/tick driven controller for an external up/down counter.
// Define COUNT_SEQ_AUTO_RELOAD_EN to reload at the limit instead of stopping in DONE.
module count_sequencer
    import count_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             btn_start,
    input  logic             btn_stop,
    input  logic             btn_load,
    input  logic             dir_sw,
    input  logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] limit,
    input  logic [WIDTH-1:0] count_in,
    output logic             cnt_load,
    output logic             cnt_step,
    output logic             cnt_up_down,
    output logic [WIDTH-1:0] load_value,
    output logic             busy,
    output logic             done,
    output logic [2:0]       state_o
);
    logic start_evt, stop_evt, load_evt;
    state_e state_q, state_d;
    logic run_after_q, run_after_d;
    logic dir_q, dir_d;
    logic [WIDTH-1:0] val_q, val_d;
    logic cap, step;

    edge_detect u_start (.clk(clk), .rst(rst), .in_i(btn_start), .evt_o(start_evt));
    edge_detect u_stop  (.clk(clk), .rst(rst), .in_i(btn_stop),  .evt_o(stop_evt));
    edge_detect u_load  (.clk(clk), .rst(rst), .in_i(btn_load),  .evt_o(load_evt));

    // Preload is captured on entry to LOAD so load_value is valid alongside cnt_load.
    always_comb begin
        state_d     = state_q;
        run_after_d = run_after_q;
        dir_d       = dir_q;
        val_d       = val_q;
        cap         = 1'b0;
        step        = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (load_evt) begin
                    state_d     = LOAD;
                    run_after_d = 1'b0;
                    cap         = 1'b1;
                end else if (start_evt) begin
                    state_d     = LOAD;
                    run_after_d = 1'b1;
                    cap         = 1'b1;
                end
            end
            LOAD: state_d = run_after_q ? RUN : IDLE;
            RUN: begin
                if (load_evt) begin
                    state_d     = LOAD;
                    run_after_d = 1'b1;
                    cap         = 1'b1;
                end else if (stop_evt) begin
                    state_d = PAUSE;
                end else if (tick) begin
                    if (count_in == limit) begin
`ifdef COUNT_SEQ_AUTO_RELOAD_EN
                        state_d     = LOAD;
                        run_after_d = 1'b1;
`else
                        state_d     = DONE;
`endif
                    end else begin
                        step = 1'b1;
                    end
                end
            end
            PAUSE: begin
                if (load_evt) begin
                    state_d     = LOAD;
                    run_after_d = 1'b1;
                    cap         = 1'b1;
                end else if (start_evt) begin
                    state_d = RUN;
                    dir_d   = dir_sw;
                end
            end
            default: state_d = IDLE;
        endcase
        if (cap) begin
            val_d = data_in;
            dir_d = dir_sw;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            run_after_q <= 1'b0;
            dir_q       <= 1'b0;
            val_q       <= '0;
        end else begin
            state_q     <= state_d;
            run_after_q <= run_after_d;
            dir_q       <= dir_d;
            val_q       <= val_d;
        end
    end

    assign cnt_load    = state_q == LOAD;
    assign cnt_step    = step;
    assign cnt_up_down = dir_q;
    assign load_value  = val_q;
    assign busy        = state_q == LOAD || state_q == RUN || state_q == PAUSE;
    assign done        = state_q == DONE;
    assign state_o     = state_q;
endmodule

// File: tb/tb_count_sequencer.sv
// tb_count_sequencer: directed checks of the count sequencer with a simple
// external counter model driving count_in.
module tb_count_sequencer;
    logic clk = 0, rst = 0, tick = 0;
    logic btn_start = 0, btn_stop = 0, btn_load = 0, dir_sw = 0;
    logic [3:0] data_in = 0, limit = 0, count_in, load_value;
    logic cnt_load, cnt_step, cnt_up_down, busy, done;
    logic [2:0] state_o;
    int total = 0, bad = 0;
`ifdef COUNT_SEQ_AUTO_RELOAD_EN
    localparam logic [2:0] TERM = 3'd1;
    localparam logic TERM_DONE = 1'b0;
`else
    localparam logic [2:0] TERM = 3'd4;
    localparam logic TERM_DONE = 1'b1;
`endif

    count_sequencer #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .tick(tick), .btn_start(btn_start), .btn_stop(btn_stop),
        .btn_load(btn_load), .dir_sw(dir_sw), .data_in(data_in), .limit(limit),
        .count_in(count_in), .cnt_load(cnt_load), .cnt_step(cnt_step),
        .cnt_up_down(cnt_up_down), .load_value(load_value), .busy(busy), .done(done),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Wrapping 4-bit counter standing in for the real datapath.
    logic [3:0] cnt;
    always @(posedge clk or negedge rst) begin
        if (!rst)          cnt <= 4'd0;
        else if (cnt_load) cnt <= load_value;
        else if (cnt_step) cnt <= cnt_up_down ? cnt + 4'd1 : cnt - 4'd1;
    end
    assign count_in = cnt;

    always @(negedge clk) begin
        if (rst) begin
            total++;
            assert (!(cnt_load && cnt_step)) else begin
                bad++;
                $error("FAIL excl: cnt_load=%0b cnt_step=%0b both required not set", cnt_load, cnt_step);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 0;
        {tick, btn_start, btn_stop, btn_load, dir_sw} = '0;
        cyc();
        cyc();
        rst = 1;
        cyc();
    endtask

    task automatic tick1(input logic exp_step);
        tick = 1;
        #1 chk("step", cnt_step, exp_step);
        cyc();
        tick = 0;
    endtask

    task automatic start_run(input logic [3:0] d, input logic dr, input logic [3:0] lim);
        data_in = d;
        dir_sw = dr;
        limit = lim;
        btn_start = 1;
        cyc();
        btn_start = 0;
        #1 chk("load_state", state_o, 1);
        chk("load_pulse", cnt_load, 1);
        chk("load_val", load_value, d);
        chk("load_dir", cnt_up_down, dr);
        chk("load_busy", busy, 1);
        cyc();
        #1 chk("run_state", state_o, 2);
        chk("run_count", count_in, d);
    endtask

    initial begin
        // Reset with start held high, then release: no event.
        rst = 0;
        btn_start = 1;
        tick = 1;
        cyc();
        cyc();
        #1 chk("rst_state", state_o, 0);
        chk("rst_load", cnt_load, 0);
        chk("rst_step", cnt_step, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_val", load_value, 0);
        chk("rst_dir", cnt_up_down, 0);
        tick = 0;
        rst = 1;
        cyc();
        cyc();
        #1 chk("held_state", state_o, 0);
        chk("held_load", cnt_load, 0);
        btn_start = 0;
        cyc();

        // Count up 3 -> 7, terminal on fifth tick.
        start_run(4'd3, 1'b1, 4'd7);
        repeat (4) tick1(1'b1);
        #1 chk("up_count", count_in, 7);
        tick1(1'b0);
        #1 chk("up_term", state_o, TERM);
        chk("up_done", done, TERM_DONE);

        // Count down through wrap: 1,0,15,14.
        do_reset();
        start_run(4'd1, 1'b0, 4'd14);
        repeat (3) tick1(1'b1);
        #1 chk("wrap_count", count_in, 14);
        tick1(1'b0);
        #1 chk("wrap_term", state_o, TERM);

        // Stop with coincident tick, dir ignored in RUN, re-sampled on resume.
        do_reset();
        start_run(4'd2, 1'b1, 4'd9);
        dir_sw = 0;
        tick1(1'b1);
        #1 chk("run_dir_hold", cnt_up_down, 1);
        chk("run_cnt3", count_in, 3);
        btn_stop = 1;
        tick = 1;
        #1 chk("stop_tick_step", cnt_step, 0);
        cyc();
        tick = 0;
        btn_stop = 0;
        #1 chk("pause_state", state_o, 3);
        chk("pause_busy", busy, 1);
        tick1(1'b0);
        data_in = 4'd8;
        btn_start = 1;
        cyc();
        btn_start = 0;
        #1 chk("resume_state", state_o, 2);
        chk("resume_dir", cnt_up_down, 0);
        chk("resume_val", load_value, 2);
        chk("resume_cnt", count_in, 3);
        tick1(1'b1);
        #1 chk("down_cnt", count_in, 2);

        // Load and stop together in RUN: load wins.
        do_reset();
        start_run(4'd4, 1'b1, 4'd9);
        data_in = 4'd6;
        btn_load = 1;
        btn_stop = 1;
        cyc();
        btn_load = 0;
        btn_stop = 0;
        #1 chk("ls_state", state_o, 1);
        chk("ls_pulse", cnt_load, 1);
        chk("ls_val", load_value, 6);
        cyc();
        #1 chk("ls_run", state_o, 2);
        chk("ls_cnt", count_in, 6);

        // Load from IDLE returns to IDLE.
        do_reset();
        data_in = 4'd9;
        dir_sw = 1;
        btn_load = 1;
        cyc();
        btn_load = 0;
        #1 chk("il_state", state_o, 1);
        chk("il_busy", busy, 1);
        cyc();
        #1 chk("il_idle", state_o, 0);
        chk("il_val", load_value, 9);
        chk("il_dir", cnt_up_down, 1);

        // Limit equals preload: terminal on first tick.
        do_reset();
        start_run(4'd5, 1'b1, 4'd5);
        tick1(1'b0);
        #1 chk("eq_term", state_o, TERM);
        chk("eq_done", done, TERM_DONE);
`ifdef COUNT_SEQ_AUTO_RELOAD_EN
        data_in = 4'd0;
        cyc();
        #1 chk("ar_run", state_o, 2);
        chk("ar_val", load_value, 5);
        tick1(1'b0);
        #1 chk("ar_loop", state_o, 1);
        chk("ar_done", done, 0);
`endif

        // Reset mid-LOAD aborts immediately.
        do_reset();
        data_in = 4'd1;
        btn_start = 1;
        cyc();
        btn_start = 0;
        #1 chk("ml_state", state_o, 1);
        rst = 0;
        #1 chk("ml_load", cnt_load, 0);
        chk("ml_state0", state_o, 0);
        chk("ml_busy", busy, 0);
        chk("ml_val", load_value, 0);
        cyc();
        rst = 1;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/count_sequencer.md
COUNT_SEQUENCER -- requirements
Module: count_sequencer

Interface
REQ-001 The block SHALL have the parameter WIDTH, default 4, which is the counter/data width.
REQ-002 The block SHALL have the port clk, input, width 1: the system clock, the single clock domain.
REQ-003 The block SHALL have the port rst, input, width 1: asynchronous, active-low reset.
REQ-004 The block SHALL have the port tick, input, width 1: one-cycle step strobe from the clock divider.
REQ-005 The block SHALL have the ports btn_start, btn_stop and btn_load, inputs, width 1 each: debounced button levels.
REQ-006 The block SHALL have the port dir_sw, input, width 1: 1 = count up, 0 = count down.
REQ-007 The block SHALL have the ports data_in, limit and count_in, inputs, width WIDTH each: preload value, terminal value, and current counter value.
REQ-008 The block SHALL have the ports cnt_load and cnt_step, outputs, width 1 each: one-cycle load pulse and one-cycle step pulse to the counter.
REQ-009 The block SHALL have the port cnt_up_down, output, width 1: the latched direction.
REQ-010 The block SHALL have the port load_value, output, width WIDTH: the latched preload value.
REQ-011 The block SHALL have the ports busy, done and state_o; busy and done are width 1, state_o is width 3 and carries the current state encoding.

Function
REQ-012 The block SHALL rising-edge-detect each btn_* input, giving a one-cycle start_evt, stop_evt or load_evt.
REQ-013 The block SHALL implement states IDLE, LOAD, RUN, PAUSE and DONE.
REQ-014 Event priority SHALL be load_evt > stop_evt > start_evt > tick when events coincide.
REQ-015 On load_evt in any state other than LOAD, the block SHALL go to LOAD.
REQ-016 In IDLE and DONE, start_evt SHALL go to LOAD.
REQ-017 LOAD SHALL last exactly one cycle, during which cnt_load=1 and load_value and cnt_up_down are captured from data_in and dir_sw.
REQ-018 LOAD SHALL go to RUN if it was entered by start_evt, or from RUN/PAUSE by load_evt; LOAD SHALL go to IDLE if it was entered from IDLE/DONE by load_evt.
REQ-019 In RUN, tick with count_in != limit SHALL give cnt_step=1 in the same cycle (combinational from tick and state, zero latency).
REQ-020 In RUN, tick with count_in == limit SHALL give no step and a transition to DONE.
REQ-021 In RUN, stop_evt SHALL go to PAUSE, and a coincident tick SHALL be suppressed.
REQ-022 In PAUSE, start_evt SHALL re-sample dir_sw into cnt_up_down and go to RUN; load_value SHALL be unchanged.
REQ-023 dir_sw changes while in RUN SHALL be ignored.
REQ-024 busy SHALL be 1 in LOAD, RUN and PAUSE; done SHALL be 1 only in DONE.
REQ-025 cnt_load and cnt_step SHALL never both be 1 in the same cycle.
REQ-026 If limit already equals the loaded value, the first tick in RUN SHALL go to DONE with zero steps.
REQ-027 Wrap-around SHALL be owned by the counter; the controller SHALL only compare count_in to limit, and SHALL NOT stop on wrap.

Reset
REQ-028 While rst=0, the block SHALL be in IDLE, all outputs SHALL be 0, and load_value SHALL be 0.
REQ-029 Edge-detect history registers SHALL reset to 1, so a button held through reset release produces no event.
REQ-030 Reset asserted in any state, including mid-LOAD, SHALL abort immediately with no residual pulse.

Configuration
REQ-031 The macro COUNT_SEQ_AUTO_RELOAD_EN SHALL select the terminal behaviour.
REQ-032 When COUNT_SEQ_AUTO_RELOAD_EN is defined, RUN at limit on tick SHALL go to LOAD, reusing the stored load_value and cnt_up_down (no data_in/dir_sw re-sample), then to RUN, with a continuous loop.
REQ-033 When COUNT_SEQ_AUTO_RELOAD_EN is defined, DONE SHALL be unreachable and done SHALL stay 0.
REQ-034 When COUNT_SEQ_AUTO_RELOAD_EN is undefined, the block SHALL behave per REQ-020.

Structure
REQ-035 The shared package count_seq_pkg SHALL hold the state enumeration (IDLE=0, LOAD=1, RUN=2, PAUSE=3, DONE=4) and the WIDTH default constant.
REQ-036 The single sub-module edge_detect (1-bit, reset value 1) SHALL be instantiated three times.

Verification
REQ-037 Scenario: reset release with btn_start held high -> state IDLE, no LOAD, all outputs 0.
REQ-038 Scenario: data_in=3, dir_sw=1, limit=7, start, 5 ticks -> one cnt_load, then 4 cnt_step pulses with count_in 3->7; the 5th tick gives DONE, done=1.
REQ-039 Scenario: in RUN, btn_stop and tick in the same cycle -> PAUSE, cnt_step=0; dir_sw toggled to 0, then start -> RUN with cnt_up_down=0.
REQ-040 Scenario: load and stop in the same cycle while in RUN -> LOAD, then RUN; stop is ignored.
REQ-041 Scenario: limit=data_in=5, start, tick -> DONE with zero steps; with COUNT_SEQ_AUTO_RELOAD_EN -> LOAD, RUN, repeating, done=0.
REQ-042 Scenario: rst asserted during a LOAD cycle -> cnt_load drops immediately; state_o=0.
